// File: rtl/tlb_nport.sv
// tlb_nport: multi-port joint TLB with kseg0/kseg1 bypass and a management
// FSM for TLBP/TLBR/TLBWI/TLBWR. Variable page size enabled by TLB_PAGEMASK_EN.
//
// state  | meaning
// S_IDLE | lookups accepted; op and operands captured when op_valid=1
// S_EXEC | management op performs its read/probe/write
// S_DONE | op_done pulse, lookups still held off
module tlb_nport #(
  parameter int ENTRIES = 32,
  parameter int PORTS   = 2,
  parameter int ASID_W  = 8,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PORTS-1:0]    lk_req,
  output logic [PORTS-1:0]    lk_ready,
  input  logic [PORTS*32-1:0] lk_vaddr,
  input  logic [PORTS-1:0]    lk_wr,
  output logic [PORTS-1:0]    lk_valid,
  output logic [PORTS*32-1:0] lk_paddr,
  output logic [PORTS*3-1:0]  lk_err,
  output logic [PORTS-1:0]    lk_cached,
  input  logic [ASID_W-1:0]   asid,
  input  logic [IW-1:0]       wired,
  input  logic                op_valid,
  input  logic [2:0]          op,
  input  logic [IW-1:0]       op_index,
  input  logic [31:0]         op_entryhi,
  input  logic [31:0]         op_entrylo0,
  input  logic [31:0]         op_entrylo1,
  input  logic [31:0]         op_pagemask,
  output logic                op_done,
  output logic [31:0]         rd_entryhi,
  output logic [31:0]         rd_entrylo0,
  output logic [31:0]         rd_entrylo1,
  output logic [31:0]         rd_pagemask,
  output logic [31:0]         probe_index,
  output logic [IW-1:0]       random
);

  typedef struct packed {
    logic [18:0]       vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  err;
    logic        cached;
  } res_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  entry_t      tlb  [ENTRIES];
  logic [11:0] mask [ENTRIES];
  state_t      state, state_nx;

  logic [2:0]    op_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   hi_q, lo0_q, lo1_q;
  logic          p_hit;
  logic [IW-1:0] p_idx;
  logic [IW-1:0] widx;
  res_t          res [PORTS];
  logic [PORTS-1:0] accept;

  function automatic logic ent_hit(input entry_t e, input logic [11:0] m,
                                   input logic [18:0] vpn, input logic [ASID_W-1:0] a);
    return (((e.vpn2 ^ vpn) & ~{7'd0, m}) == 19'd0) && (e.g || (e.asid == a));
  endfunction

  // Even/odd select sits just above the page offset, which widens with the mask.
  function automatic logic [4:0] sel_bit(input logic [11:0] m);
    logic [4:0] n;
    n = 5'd12;
    for (int b = 0; b < 12; b++) n = n + {4'd0, m[b]};
    return n;
  endfunction

  // Descending scan so the lowest matching index is the one kept.
  function automatic void find(input logic [18:0] vpn, input logic [ASID_W-1:0] a,
                               output logic hit, output logic [IW-1:0] idx);
    hit = 1'b0;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (ent_hit(tlb[i], mask[i], vpn, a)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  endfunction

  function automatic res_t xlate(input logic [31:0] va, input logic wr);
    res_t          r;
    logic          hit;
    logic [IW-1:0] idx;
    logic          odd;
    logic [31:0]   offm;
    logic [19:0]   pfn;
    logic [2:0]    c;
    logic          d, v;
    r = '0;
    hit = 1'b0;
    idx = '0;
    if (va[31:29] == 3'b100) begin
      r.paddr  = va - 32'h8000_0000;
      r.cached = 1'b1;
    end else if (va[31:29] == 3'b101) begin
      r.paddr = va - 32'hA000_0000;
    end else begin
      find(va[31:13], asid, hit, idx);
      odd  = va[sel_bit(mask[idx])];
      pfn  = odd ? tlb[idx].pfn1 : tlb[idx].pfn0;
      c    = odd ? tlb[idx].c1   : tlb[idx].c0;
      d    = odd ? tlb[idx].d1   : tlb[idx].d0;
      v    = odd ? tlb[idx].v1   : tlb[idx].v0;
      offm = {8'd0, mask[idx], 12'hFFF};
      if (!hit)           r.err = wr ? 3'd2 : 3'd1;
      else if (!v)        r.err = wr ? 3'd4 : 3'd3;
      else if (wr && !d)  r.err = 3'd5;
      else begin
        r.paddr  = ({pfn, 12'd0} & ~offm) | (va & offm);
        r.cached = (c == 3'd3);
      end
    end
    return r;
  endfunction

  always_comb
    for (int p = 0; p < PORTS; p++) res[p] = xlate(lk_vaddr[p*32 +: 32], lk_wr[p]);

  always_comb find(hi_q[31:13], hi_q[ASID_W-1:0], p_hit, p_idx);

  assign accept = lk_req & lk_ready;
  assign widx   = (op_q == 3'd3) ? random : idx_q;

  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    lk_ready = '0;
    op_done  = 1'b0;
    case (state)
      S_IDLE: if (op_valid) state_nx = S_EXEC;
              else          lk_ready = '1;
      S_EXEC: state_nx = S_DONE;
      S_DONE: begin
        op_done  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      lk_valid  <= '0;
      lk_paddr  <= '0;
      lk_err    <= '0;
      lk_cached <= '0;
    end else begin
      lk_valid <= accept;
      for (int p = 0; p < PORTS; p++)
        if (accept[p]) begin
          lk_paddr[p*32 +: 32] <= res[p].paddr;
          lk_err[p*3 +: 3]     <= res[p].err;
          lk_cached[p]         <= res[p].cached;
        end
    end

`ifdef TLB_PAGEMASK_EN
  logic [11:0] pm_q;
  logic        unused_bits;
  assign unused_bits = ^{op_pagemask[31:25], op_pagemask[12:0], hi_q[12:ASID_W],
                         lo0_q[31:26], lo1_q[31:26]};
`else
  logic        unused_bits;
  assign unused_bits = ^{op_pagemask, hi_q[12:ASID_W], lo0_q[31:26], lo1_q[31:26]};
  always_comb for (int i = 0; i < ENTRIES; i++) mask[i] = 12'd0;
`endif

  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tlb[i] <= '0;
`ifdef TLB_PAGEMASK_EN
      for (int i = 0; i < ENTRIES; i++) mask[i] <= '0;
      pm_q <= '0;
`endif
      op_q        <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      lo0_q       <= '0;
      lo1_q       <= '0;
      rd_entryhi  <= '0;
      rd_entrylo0 <= '0;
      rd_entrylo1 <= '0;
      rd_pagemask <= '0;
      probe_index <= '0;
      random      <= IW'(ENTRIES - 1);
    end else begin
      random <= (random <= wired) ? IW'(ENTRIES - 1) : random - 1'b1;
      if (state == S_IDLE && op_valid) begin
        op_q  <= op;
        idx_q <= op_index;
        hi_q  <= op_entryhi;
        lo0_q <= op_entrylo0;
        lo1_q <= op_entrylo1;
`ifdef TLB_PAGEMASK_EN
        pm_q  <= op_pagemask[24:13];
`endif
      end
      if (state == S_EXEC)
        case (op_q)
          3'd0: probe_index <= p_hit ? 32'(p_idx) : 32'h8000_0000;
          3'd1: begin
            rd_entryhi  <= {tlb[idx_q].vpn2, 13'd0} | 32'(tlb[idx_q].asid);
            rd_entrylo0 <= {6'd0, tlb[idx_q].pfn0, tlb[idx_q].c0, tlb[idx_q].d0,
                            tlb[idx_q].v0, tlb[idx_q].g};
            rd_entrylo1 <= {6'd0, tlb[idx_q].pfn1, tlb[idx_q].c1, tlb[idx_q].d1,
                            tlb[idx_q].v1, tlb[idx_q].g};
            rd_pagemask <= {7'd0, mask[idx_q], 13'd0};
          end
          3'd2, 3'd3: begin
            tlb[widx] <= '{vpn2: hi_q[31:13], asid: hi_q[ASID_W-1:0],
                           g: lo0_q[0] & lo1_q[0],
                           pfn0: lo0_q[25:6], c0: lo0_q[5:3], d0: lo0_q[2], v0: lo0_q[1],
                           pfn1: lo1_q[25:6], c1: lo1_q[5:3], d1: lo1_q[2], v1: lo1_q[1]};
`ifdef TLB_PAGEMASK_EN
            mask[widx] <= pm_q;
`endif
          end
          default: ;
        endcase
    end

endmodule

// File: tb/tb_tlb_nport.sv
// Self-checking bench for tlb_nport: directed scenarios plus randomized
// lookups/management ops compared against a CP0-image reference model.
module tb_tlb_nport;
  localparam int ENTRIES = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lk_req, lk_ready, lk_wr, lk_valid, lk_cached;
  logic [63:0] lk_vaddr, lk_paddr;
  logic [5:0]  lk_err;
  logic [7:0]  asid;
  logic [4:0]  wired, op_index, random;
  logic        op_valid, op_done;
  logic [2:0]  op;
  logic [31:0] op_entryhi, op_entrylo0, op_entrylo1, op_pagemask;
  logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1, rd_pagemask, probe_index;

  int checks = 0, passed = 0, fails = 0;

  logic [31:0] m_hi [ENTRIES], m_lo0 [ENTRIES], m_lo1 [ENTRIES];
  logic [4:0]  m_rand;

  tlb_nport dut (
    .clk(clk), .reset(reset),
    .lk_req(lk_req), .lk_ready(lk_ready), .lk_vaddr(lk_vaddr), .lk_wr(lk_wr),
    .lk_valid(lk_valid), .lk_paddr(lk_paddr), .lk_err(lk_err), .lk_cached(lk_cached),
    .asid(asid), .wired(wired), .op_valid(op_valid), .op(op), .op_index(op_index),
    .op_entryhi(op_entryhi), .op_entrylo0(op_entrylo0), .op_entrylo1(op_entrylo1),
    .op_pagemask(op_pagemask), .op_done(op_done),
    .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
    .rd_pagemask(rd_pagemask), .probe_index(probe_index), .random(random)
  );

  always #5 clk = ~clk;

  // Random register behaviour: count down, wrap to ENTRIES-1 at or below wired.
  always @(posedge clk)
    if (reset) m_rand <= 5'd31;
    else       m_rand <= (m_rand <= wired) ? 5'd31 : m_rand - 5'd1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_find(input logic [31:0] hi, input logic [7:0] a);
    for (int i = 0; i < ENTRIES; i++)
      if (m_hi[i][31:13] == hi[31:13] &&
          ((m_lo0[i][0] & m_lo1[i][0]) == 1'b1 || m_hi[i][7:0] == a))
        return i;
    return -1;
  endfunction

  task automatic ref_xlate(input logic [31:0] va, input logic wr,
                           output logic [31:0] pa, output logic [2:0] er, output logic ca);
    int h;
    logic [31:0] lo;
    pa = 0; er = 0; ca = 0;
    if (va[31:29] == 3'b100) begin
      pa = va - 32'h8000_0000; ca = 1;
    end else if (va[31:29] == 3'b101) begin
      pa = va - 32'hA000_0000;
    end else begin
      h = ref_find(va, asid);
      if (h < 0) er = wr ? 3'd2 : 3'd1;
      else begin
        lo = ((va >> 12) % 2 == 1) ? m_lo1[h] : m_lo0[h];
        if (((lo >> 1) & 1) == 0)           er = wr ? 3'd4 : 3'd3;
        else if (wr && ((lo >> 2) & 1) == 0) er = 3'd5;
        else begin
          pa = ((lo >> 6) & 32'hF_FFFF) * 4096 + va % 4096;
          ca = ((lo >> 3) & 7) == 3;
        end
      end
    end
  endtask

  task automatic do_reset;
    reset = 1; lk_req = 0; op_valid = 0;
    tick; tick;
    reset = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0;
    end
  endtask

  task automatic look(input logic [1:0] req, input logic [31:0] va0, input logic w0,
                      input logic [31:0] va1, input logic w1);
    logic [31:0] epa [2];
    logic [2:0]  eer [2];
    logic        eca [2];
    lk_req = req; lk_vaddr = {va1, va0}; lk_wr = {w1, w0};
    ref_xlate(va0, w0, epa[0], eer[0], eca[0]);
    ref_xlate(va1, w1, epa[1], eer[1], eca[1]);
    #1 chk("lk_ready_idle", {30'd0, lk_ready}, 32'd3);
    tick;
    lk_req = 0;
    chk("lk_valid", {30'd0, lk_valid}, {30'd0, req});
    for (int p = 0; p < 2; p++)
      if (req[p]) begin
        chk("lk_err", {29'd0, lk_err[p*3 +: 3]}, {29'd0, eer[p]});
        chk("lk_paddr", lk_paddr[p*32 +: 32], epa[p]);
        chk("lk_cached", {31'd0, lk_cached[p]}, {31'd0, eca[p]});
      end
  endtask

  task automatic mgmt(input logic [2:0] o, input logic [4:0] idx, input logic [31:0] hi,
                      input logic [31:0] lo0, input logic [31:0] lo1, output logic [4:0] widx);
    op_valid = 1; op = o; op_index = idx;
    op_entryhi = hi; op_entrylo0 = lo0; op_entrylo1 = lo1; op_pagemask = $urandom;
    lk_req = 2'b11; lk_vaddr = {32'hBFC0_0000, 32'h8000_0000}; lk_wr = 0;
    #1 chk("ready_opvalid", {30'd0, lk_ready}, 0);
    tick;
    widx = (o == 3'd3) ? m_rand : idx;
    chk("random_exec", {27'd0, random}, {27'd0, m_rand});
    chk("ready_exec", {30'd0, lk_ready}, 0);
    chk("valid_exec", {30'd0, lk_valid}, 0);
    chk("done_exec", {31'd0, op_done}, 0);
    tick;
    chk("ready_done", {30'd0, lk_ready}, 0);
    chk("done_pulse", {31'd0, op_done}, 1);
    if (o == 3'd2 || o == 3'd3) begin
      m_hi[widx] = hi; m_lo0[widx] = lo0; m_lo1[widx] = lo1;
    end
    op_valid = 0; lk_req = 0;
    tick;
    chk("done_clear", {31'd0, op_done}, 0);
    chk("valid_after_op", {30'd0, lk_valid}, 0);
  endtask

  task automatic check_tlbr(input logic [4:0] idx);
    logic [4:0] w;
    logic       g;
    mgmt(3'd1, idx, 0, 0, 0, w);
    g = m_lo0[idx][0] & m_lo1[idx][0];
    chk("rd_entryhi", rd_entryhi, {m_hi[idx][31:13], 5'd0, m_hi[idx][7:0]});
    chk("rd_entrylo0", rd_entrylo0, {6'd0, m_lo0[idx][25:1], g});
    chk("rd_entrylo1", rd_entrylo1, {6'd0, m_lo1[idx][25:1], g});
    chk("rd_pagemask", rd_pagemask, 0);
  endtask

  task automatic check_tlbp(input logic [31:0] hi);
    logic [4:0] w;
    int         h;
    h = ref_find(hi, hi[7:0]);
    mgmt(3'd0, 0, hi, 0, 0, w);
    chk("probe_index", probe_index, (h < 0) ? 32'h8000_0000 : 32'(h));
  endtask

  initial begin
    logic [4:0]  w;
    logic [31:0] hi, va0, va1;
    lk_req = 0; lk_wr = 0; lk_vaddr = 0; asid = 0; wired = 0;
    op_valid = 0; op = 0; op_index = 0;
    op_entryhi = 0; op_entrylo0 = 0; op_entrylo1 = 0; op_pagemask = 0;
    do_reset;

    chk("rst_valid", {30'd0, lk_valid}, 0);
    chk("rst_err", {26'd0, lk_err}, 0);
    chk("rst_paddr_lo", lk_paddr[31:0], 0);
    chk("rst_paddr_hi", lk_paddr[63:32], 0);
    chk("rst_done", {31'd0, op_done}, 0);
    chk("rst_probe", probe_index, 0);
    chk("rst_rd_lo0", rd_entrylo0, 0);
    chk("rst_random", {27'd0, random}, 31);

    look(2'b11, 32'h0040_0000, 0, 32'hBFC0_0000, 1);
    chk("refill_load", {29'd0, lk_err[2:0]}, 1);
    chk("kseg1_paddr", lk_paddr[63:32], 32'h1FC0_0000);
    chk("kseg1_cached", {31'd0, lk_cached[1]}, 0);
    chk("kseg1_err", {29'd0, lk_err[5:3]}, 0);

    mgmt(3'd2, 5, 32'h0040_0012, 32'h0004_8D1E, 32'h0, w);
    asid = 8'h12;
    look(2'b01, 32'h0040_0ABC, 0, 0, 0);
    chk("hit_paddr", lk_paddr[31:0], 32'h0123_4ABC);
    chk("hit_cached", {31'd0, lk_cached[0]}, 1);
    asid = 8'h13;
    look(2'b10, 0, 0, 32'h0040_0ABC, 0);
    chk("asid_miss", {29'd0, lk_err[5:3]}, 1);

    asid = 8'h12;
    mgmt(3'd2, 5, 32'h0040_0012, 32'h0004_8D1E, 32'h0000_155A, w);
    look(2'b01, 32'h0040_1000, 1, 0, 0);
    chk("modified", {29'd0, lk_err[2:0]}, 5);
    mgmt(3'd2, 5, 32'h0040_0012, 32'h0004_8D1E, 32'h0000_1558, w);
    look(2'b01, 32'h0040_1000, 0, 0, 0);
    chk("invalid_l", {29'd0, lk_err[2:0]}, 3);

    check_tlbp(32'h0040_0012);
    chk("probe_hit5", probe_index, 5);
    check_tlbp(32'h0080_0012);
    chk("probe_miss", probe_index, 32'h8000_0000);
    check_tlbr(5);
    chk("tlbr_lo0", rd_entrylo0, 32'h0004_8D1E);

    wired = 30;
    do_reset;
    chk("rand_0", {27'd0, random}, 31);
    tick; chk("rand_1", {27'd0, random}, 30);
    tick; chk("rand_2", {27'd0, random}, 31);
    tick; chk("rand_3", {27'd0, random}, 30);
    mgmt(3'd3, 0, 32'h0200_0000, 32'h0000_00DE, 32'h0, w);
    check_tlbr(w);
    chk("tlbwr_hi", rd_entryhi, 32'h0200_0000);
    check_tlbr((w == 5'd31) ? 5'd30 : 5'd31);
    chk("tlbwr_other", rd_entryhi, 0);

    // Reset in EXEC must abort the write and suppress op_done.
    op_valid = 1; op = 3'd2; op_index = 7;
    op_entryhi = 32'h0100_0000; op_entrylo0 = 32'h0000_00DE; op_entrylo1 = 0;
    tick;
    reset = 1; op_valid = 0;
    tick;
    reset = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0;
    end
    chk("abort_done0", {31'd0, op_done}, 0);
    tick;
    chk("abort_done1", {31'd0, op_done}, 0);
    asid = 0;
    look(2'b01, 32'h0100_0000, 0, 0, 0);
    chk("abort_nowrite", {29'd0, lk_err[2:0]}, 1);

    wired = 4;
    for (int n = 0; n < 14; n++) begin
      hi = ((32'h200 + $urandom_range(0, 3)) << 13) | ($urandom_range(0, 1) ? 32'h12 : 32'h13);
      mgmt((n % 3 == 0) ? 3'd3 : 3'd2, 5'($urandom_range(0, 31)), hi,
           $urandom & 32'h03FF_FFFF, $urandom & 32'h03FF_FFFF, w);
    end
    for (int n = 0; n < 120; n++) begin
      asid = $urandom_range(0, 1) ? 8'h12 : 8'h13;
      va0 = ($urandom_range(0, 5) < 4) ? (((32'h200 + $urandom_range(0, 4)) << 13) | ($urandom % 8192))
                                       : (($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | ($urandom & 32'h3FFF_FFFF));
      va1 = ($urandom_range(0, 5) < 4) ? (((32'h200 + $urandom_range(0, 4)) << 13) | ($urandom % 8192))
                                       : $urandom;
      look(2'($urandom_range(1, 3)), va0, 1'($urandom_range(0, 1)), va1, 1'($urandom_range(0, 1)));
      if (n % 15 == 0)
        check_tlbp(((32'h200 + $urandom_range(0, 4)) << 13) | ($urandom_range(0, 1) ? 32'h12 : 32'h13));
      if (n % 30 == 0) check_tlbr(5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
